// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back select, 2R1W register file with write-first bypass, debug port, commit counter
//
// Purpose:
//   Selects the write-back value (load data or ALU result), commits it to the
//   architectural register array and serves the decode stage's two read ports.
//   A read that hits the register being written this cycle returns the new
//   value. Register 0 is hardwired to zero. A debug read port shows the array
//   contents only, and WbCount counts committed writes.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        asynchronous active-low reset
//   RegWriteW  W-stage register write enable
//   MemtoRegW  1 selects ReadDataW, 0 selects ALUOutW
//   ReadDataW  W-stage load data
//   ALUOutW    W-stage ALU result
//   WriteRegW  W-stage destination register
//   A1, A2     decode read addresses
//   RD1, RD2   decode read data (combinational, bypassed)
//   ResultW    selected write-back value
//   DbgAddr    debug read address
//   DbgData    debug read data (array only, no bypass)
//   WbCount    number of committed register writes (wraps)

module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] ResultW,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData,
    output logic [CNT_W-1:0]  WbCount
);

    localparam int              NREGS   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

    // rst is folded in so that the bypass is also dead while reset is held,
    // not just the array update.
    assign commit = rst & RegWriteW & (WriteRegW != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            WbCount <= '0;
        end else if (commit) begin
            regs[WriteRegW] <= ResultW;
            WbCount         <= WbCount + CNT_ONE;
        end
    end

    // Each port resolves independently: $0 first, then the write-first bypass,
    // then the array.
    always_comb begin
        RD1 = regs[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (commit && (WriteRegW == A1)) begin
            RD1 = ResultW;
        end
    end

    always_comb begin
        RD2 = regs[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end else if (commit && (WriteRegW == A2)) begin
            RD2 = ResultW;
        end
    end

    assign DbgData = (DbgAddr == '0) ? '0 : regs[DbgAddr];

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed vector bench for wb_regfile

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteW = 1'b0;
    logic        MemtoRegW = 1'b0;
    logic [31:0] ReadDataW = '0;
    logic [31:0] ALUOutW = '0;
    logic [4:0]  WriteRegW = '0;
    logic [4:0]  A1 = '0;
    logic [4:0]  A2 = '0;
    logic [4:0]  DbgAddr = '0;
    logic [31:0] RD1, RD2, ResultW, DbgData;
    logic [3:0]  WbCount;

    int checks = 0;
    int failures = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .WriteRegW (WriteRegW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .ResultW   (ResultW),
        .DbgAddr   (DbgAddr),
        .DbgData   (DbgData),
        .WbCount   (WbCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  dbg;
        logic [31:0] e_res;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_dbg;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Each vector is checked just before the posedge that may commit it,
        // so e_dbg and e_cnt reflect the previous vectors' commits only.
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        32'h1234_5678, 5'd5,  5'd5,  5'd6,  5'd5,
                     32'h1234_5678, 32'h1234_5678, 32'h0,         32'h0,         4'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0,  5'd5,  5'd5,  5'd5,
                     32'h0,         32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 4'd1};
        vecs[2]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1,        5'd9,  5'd9,  5'd9,  5'd9,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         4'd1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 5'd0,  5'd0,  5'd9,  5'd0,
                     32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF, 32'h0,         4'd2};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0,  5'd0,  5'd5,  5'd9,
                     32'h0,         32'h0,         32'h1234_5678, 32'hDEAD_BEEF, 4'd2};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'hA5A5_A5A5, 5'd31, 5'd31, 5'd5,  5'd31,
                     32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h1234_5678, 32'h0,         4'd2};
        vecs[6]  = '{1'b0, 1'b1, 32'h0,        32'h77,        5'd31, 5'd31, 5'd9,  5'd31,
                     32'h0,         32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 4'd3};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        32'h1111_1111, 5'd5,  5'd6,  5'd5,  5'd5,
                     32'h1111_1111, 32'h0,         32'h1111_1111, 32'h1234_5678, 4'd3};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0,  5'd5,  5'd5,  5'd5,
                     32'h0,         32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 4'd4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0000_CAFE, 5'd6,  5'd6,  5'd6,  5'd6,
                     32'h0000_CAFE, 32'h0,         32'h0,         32'h0,         4'd4};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0,  5'd6,  5'd0,  5'd6,
                     32'h0,         32'h0,         32'h0,         32'h0,         4'd4};

        // Reset state
        #2;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        check("reset_dbg", DbgData, 32'h0);
        check("reset_cnt", {28'h0, WbCount}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            RegWriteW = vecs[i].we;
            MemtoRegW = vecs[i].m2r;
            ReadDataW = vecs[i].rdata;
            ALUOutW   = vecs[i].alu;
            WriteRegW = vecs[i].wreg;
            A1        = vecs[i].a1;
            A2        = vecs[i].a2;
            DbgAddr   = vecs[i].dbg;
            #1;
            check($sformatf("vec%0d_result", i), ResultW, vecs[i].e_res);
            check($sformatf("vec%0d_rd1", i), RD1, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), RD2, vecs[i].e_rd2);
            check($sformatf("vec%0d_dbg", i), DbgData, vecs[i].e_dbg);
            check($sformatf("vec%0d_cnt", i), {28'h0, WbCount}, {28'h0, vecs[i].e_cnt});
            @(negedge clk);
        end

        // Mid-cycle asynchronous reset while a write is pending
        RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUOutW = 32'h55; WriteRegW = 5'd7;
        A1 = 5'd7; A2 = 5'd5; DbgAddr = 5'd5;
        #1;
        check("pre_rst_bypass", RD1, 32'h55);
        check("pre_rst_rd2", RD2, 32'h1111_1111);
        check("pre_rst_cnt", {28'h0, WbCount}, 32'h4);
        #1 rst = 1'b0;
        #1;
        check("rst_bypass_off", RD1, 32'h0);
        check("rst_rd2_clear", RD2, 32'h0);
        check("rst_dbg_clear", DbgData, 32'h0);
        check("rst_cnt_clear", {28'h0, WbCount}, 32'h0);
        check("rst_result_live", ResultW, 32'h55);
        DbgAddr = 5'd7;
        @(posedge clk);
        #1;
        check("rst_no_write", DbgData, 32'h0);
        check("rst_no_count", {28'h0, WbCount}, 32'h0);
        RegWriteW = 1'b0;
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a); A2 = 5'(a); DbgAddr = 5'(a);
            #1;
            check($sformatf("rst_all_rd1_%0d", a), RD1, 32'h0);
            check($sformatf("rst_all_rd2_%0d", a), RD2, 32'h0);
            check($sformatf("rst_all_dbg_%0d", a), DbgData, 32'h0);
        end
        @(negedge clk);
        RegWriteW = 1'b1; ALUOutW = 32'h55; WriteRegW = 5'd7;
        A1 = 5'd7; A2 = 5'd0; DbgAddr = 5'd7;
        rst = 1'b1;
        #1;
        check("release_bypass", RD1, 32'h55);
        check("release_dbg_old", DbgData, 32'h0);
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        check("release_dbg_new", DbgData, 32'h55);
        check("release_cnt", {28'h0, WbCount}, 32'h1);

        // Counter wrap with CNT_W=4: 17 commits to $3
        @(negedge clk);
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("wrap_start", {28'h0, WbCount}, 32'h0);
        RegWriteW = 1'b1; MemtoRegW = 1'b0; WriteRegW = 5'd3; DbgAddr = 5'd3;
        A1 = 5'd3; A2 = 5'd7;
        for (int k = 0; k < 17; k++) begin
            ALUOutW = 32'(k + 100);
            @(posedge clk);
            #1;
            check($sformatf("wrap_cnt_%0d", k), {28'h0, WbCount}, 32'((k + 1) % 16));
            check($sformatf("wrap_dbg_%0d", k), DbgData, 32'(k + 100));
        end
        RegWriteW = 1'b0;
        #1;
        check("wrap_final_rd1", RD1, 32'd116);
        check("wrap_other_reg", RD2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
